// File: rtl/mul_rr_sched.sv
// mul_rr_sched: round-robin front end that time-shares one shift-add multiplier
// among NREQ requesters, with a watchdog that aborts a stalled multiplication.
//
// Request handshake: a requester raises req_valid[i] with its operands stable
// and keeps them stable until it sees req_ready[i]. An operand pair is taken on
// a rising edge where both req_valid[i] and req_ready[i] are high. req_ready is
// only raised in IDLE, for exactly one requester (the round-robin winner), and
// it may depend on req_valid in the same cycle.
module mul_rr_sched #(
  parameter int NREQ    = 4,
  parameter int DWIDTH  = 4,
  parameter int OWIDTH  = 2 * DWIDTH,
  parameter int TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DWIDTH-1:0]   req_x,
  input  logic [NREQ*DWIDTH-1:0]   req_y,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [OWIDTH-1:0]        rsp_z,
  output logic                     rsp_err,
  output logic [DWIDTH-1:0]        mul_xin,
  output logic [DWIDTH-1:0]        mul_yin,
  output logic                     mul_ivalid,
  input  logic [OWIDTH-1:0]        mul_zout,
  input  logic                     mul_ovalid,
  output logic                     busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
  localparam logic [NREQ-1:0] ONE      = NREQ'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  state_t              state_q;
  logic [PW-1:0]       ptr_q;
  logic [PW-1:0]       owner_q;
  logic [CW-1:0]       cnt_q;
  logic [CW-1:0]       cnt_d;
  logic [DWIDTH-1:0]   xin_q;
  logic [DWIDTH-1:0]   yin_q;
  logic                ivalid_q;
  logic [NREQ-1:0]     rsp_valid_q;
  logic [OWIDTH-1:0]   rsp_z_q;
  logic                rsp_err_q;

  logic                grant_found;
  logic [PW-1:0]       grant_idx;
  logic [PW-1:0]       cand;
  logic                handshake;

  // Round-robin search: first valid requester strictly after the last winner.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = PW'((int'(ptr_q) + k) % NREQ);
      if (!grant_found && req_valid[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign req_ready = (state_q == S_IDLE && grant_found) ? (ONE << grant_idx) : '0;
  assign handshake = (state_q == S_IDLE) && grant_found;
  assign cnt_d     = cnt_q + CNT_ONE;

  assign mul_xin    = xin_q;
  assign mul_yin    = yin_q;
  assign mul_ivalid = ivalid_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_z      = rsp_z_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = (state_q != S_IDLE);

  // Scheduler FSM: accept, pulse the multiplier, wait (with watchdog), respond.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      ptr_q       <= PW'(NREQ - 1);
      owner_q     <= '0;
      cnt_q       <= '0;
      xin_q       <= '0;
      yin_q       <= '0;
      ivalid_q    <= 1'b0;
      rsp_valid_q <= '0;
      rsp_z_q     <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (handshake) begin
            xin_q    <= req_x[int'(grant_idx)*DWIDTH +: DWIDTH];
            yin_q    <= req_y[int'(grant_idx)*DWIDTH +: DWIDTH];
            owner_q  <= grant_idx;
            ptr_q    <= grant_idx;
            ivalid_q <= 1'b1;
            state_q  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          // The pulse lasts exactly the ISSUE cycle; the watchdog starts fresh.
          ivalid_q <= 1'b0;
          cnt_q    <= '0;
          state_q  <= S_WAIT;
        end
        S_WAIT: begin
          // A result arriving on the last watchdog cycle still wins.
          if (mul_ovalid) begin
            rsp_z_q     <= mul_zout;
            rsp_err_q   <= 1'b0;
            rsp_valid_q <= ONE << owner_q;
            state_q     <= S_RESP;
          end else begin
            cnt_q <= cnt_d;
            if (cnt_d == CNT_LAST) begin
              rsp_z_q     <= '0;
              rsp_err_q   <= 1'b1;
              rsp_valid_q <= ONE << owner_q;
              state_q     <= S_RESP;
            end
          end
        end
        S_RESP: begin
          rsp_valid_q <= '0;
          rsp_z_q     <= '0;
          rsp_err_q   <= 1'b0;
          xin_q       <= '0;
          yin_q       <= '0;
          state_q     <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_rr_sched.sv
// tb_mul_rr_sched: directed + randomized checks of the round-robin multiplier
// scheduler against a behavioural multiplier stub and a reference model.
module tb_mul_rr_sched;

  localparam int NREQ = 4;
  localparam int DW   = 4;
  localparam int OW   = 2 * DW;
  localparam int TO   = 64;
  localparam int EW   = NREQ + OW + 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  // ---------------- DUT signals ----------------
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*DW-1:0] req_x;
  logic [NREQ*DW-1:0] req_y;
  logic [NREQ-1:0]    rsp_valid;
  logic [OW-1:0]      rsp_z;
  logic               rsp_err;
  logic [DW-1:0]      mul_xin;
  logic [DW-1:0]      mul_yin;
  logic               mul_ivalid;
  logic [OW-1:0]      mul_zout;
  logic               mul_ovalid;
  logic               busy;

  mul_rr_sched #(.NREQ(NREQ), .DWIDTH(DW), .OWIDTH(OW), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_x      (req_x),
    .req_y      (req_y),
    .rsp_valid  (rsp_valid),
    .rsp_z      (rsp_z),
    .rsp_err    (rsp_err),
    .mul_xin    (mul_xin),
    .mul_yin    (mul_yin),
    .mul_ivalid (mul_ivalid),
    .mul_zout   (mul_zout),
    .mul_ovalid (mul_ovalid),
    .busy       (busy)
  );

  // ---------------- multiplier stub ----------------
  // Answers L edges after sampling i_valid; disabled stub never answers.
  logic          stub_en  = 1'b1;
  int            stub_lat = 2;
  int            pend     = 0;
  logic          stub_ov  = 1'b0;
  logic [OW-1:0] stub_z   = '0;

  always @(posedge clk) begin
    stub_ov <= 1'b0;
    stub_z  <= OW'($urandom);
    if (mul_ivalid && stub_en) begin
      pend <= stub_lat;
    end else if (pend != 0) begin
      pend <= pend - 1;
      if (pend == 1) begin
        stub_ov <= 1'b1;
        stub_z  <= OW'(int'(mul_xin) * int'(mul_yin));
      end
    end
  end

  assign mul_ovalid = stub_ov;
  assign mul_zout   = stub_z;

  // ---------------- scoreboard / model state ----------------
  logic [EW-1:0]   exp_q[$];
  int              n_tests = 0;
  int              n_fail  = 0;
  int              model_ptr;
  logic [NREQ-1:0] pend_v;
  logic [DW-1:0]   op_x[NREQ];
  logic [DW-1:0]   op_y[NREQ];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Round-robin rule: first valid requester after the previous winner.
  function automatic int model_winner(input logic [NREQ-1:0] v);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (model_ptr + k) % NREQ;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Single-request invariants on every cycle out of reset.
  always @(negedge clk) begin
    if (rstn === 1'b1) begin
      check("ready_onehot0", 32'($onehot0(req_ready)), 32'd1);
      check("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic apply_inputs();
    req_valid = pend_v;
    for (int i = 0; i < NREQ; i++) begin
      req_x[i*DW +: DW] = op_x[i];
      req_y[i*DW +: DW] = op_y[i];
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn      = 1'b0;
    pend_v    = '0;
    req_valid = '0;
    repeat (2) @(negedge clk);
    rstn      = 1'b1;
    model_ptr = NREQ - 1;
  endtask

  // One full transaction; ends in the RESP cycle. drop: winner leaves after accept.
  task automatic txn(input bit drop);
    int            g;
    int            n;
    int            n_exp;
    logic [OW-1:0] ez;
    logic [EW-1:0] e;
    @(posedge clk); #1;
    apply_inputs();
    g = model_winner(pend_v);
    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_rsp_clear", 32'({rsp_valid, rsp_z, rsp_err}), 32'd0);
    if (g < 0) begin
      check("no_ready", 32'(req_ready), 32'd0);
      return;
    end
    check("grant", 32'(req_ready), 32'(1 << g));
    ez    = stub_en ? OW'(int'(op_x[g]) * int'(op_y[g])) : '0;
    n_exp = stub_en ? stub_lat + 2 : TO;
    exp_q.push_back({NREQ'(1 << g), ez, ~stub_en});
    model_ptr = g;
    @(posedge clk); #1;
    if (drop) begin
      pend_v[g] = 1'b0;
      req_valid = pend_v;
    end
    @(negedge clk);
    check("issue_ivalid", 32'(mul_ivalid), 32'd1);
    check("issue_xin", 32'(mul_xin), 32'(op_x[g]));
    check("issue_yin", 32'(mul_yin), 32'(op_y[g]));
    check("issue_busy", 32'(busy), 32'd1);
    n = 0;
    while (rsp_valid == '0 && n < TO + 10) begin
      @(negedge clk);
      n++;
      if (n == 1) check("ivalid_pulse", 32'(mul_ivalid), 32'd0);
    end
    check("rsp_seen", 32'(rsp_valid != '0), 32'd1);
    check("rsp_latency", 32'(n), 32'(n_exp));
    check("resp_no_ready", 32'(req_ready), 32'd0);
    check("resp_xin_hold", 32'(mul_xin), 32'(op_x[g]));
    e = exp_q.pop_front();
    check("rsp", 32'({rsp_valid, rsp_z, rsp_err}), 32'(e));
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    rstn      = 1'b0;
    pend_v    = '0;
    req_valid = '0;
    req_x     = '0;
    req_y     = '0;
    model_ptr = NREQ - 1;
    for (int i = 0; i < NREQ; i++) begin
      op_x[i] = '0;
      op_y[i] = '0;
    end
    #1;
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rsp_z", 32'(rsp_z), 32'd0);
    check("rst_rsp_err", 32'(rsp_err), 32'd0);
    check("rst_xin", 32'(mul_xin), 32'd0);
    check("rst_yin", 32'(mul_yin), 32'd0);
    check("rst_ivalid", 32'(mul_ivalid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Single request 5*3 from requester 0.
    op_x[0] = 4'd5; op_y[0] = 4'd3; stub_lat = 2;
    pend_v = 4'b0001;
    txn(1'b1);

    // All four valid after reset: served 0,1,2,3 with products 2,4,6,8.
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      op_x[i] = DW'(i + 1);
      op_y[i] = 4'd2;
    end
    pend_v = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      stub_lat = i + 1;
      txn(1'b1);
    end

    // Requesters 1 and 3 held valid: strict alternation.
    pend_v = 4'b1010;
    op_x[1] = 4'd6; op_y[1] = 4'd7;
    op_x[3] = 4'd9; op_y[3] = 4'd11;
    for (int i = 0; i < 4; i++) txn(1'b0);
    pend_v = '0;

    // Largest operands on requester 2.
    op_x[2] = 4'd15; op_y[2] = 4'd15; stub_lat = 3;
    pend_v = 4'b0100;
    txn(1'b1);

    // Randomized patterns, operands and latencies.
    for (int t = 0; t < 24; t++) begin
      pend_v = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < NREQ; i++) begin
        op_x[i] = DW'($urandom_range(0, 15));
        op_y[i] = DW'($urandom_range(0, 15));
      end
      stub_lat = $urandom_range(1, 8);
      txn(1'b1);
    end

    // Stalled multiplier: watchdog abort, then normal service resumes.
    pend_v = '0;
    stub_en = 1'b0;
    op_x[1] = 4'd4; op_y[1] = 4'd4;
    pend_v = 4'b0010;
    txn(1'b1);
    stub_en = 1'b1;
    stub_lat = 2;
    op_x[2] = 4'd3; op_y[2] = 4'd13;
    pend_v = 4'b0100;
    txn(1'b1);

    // Reset while waiting on the multiplier; its late answer must be ignored.
    op_x[1] = 4'd7; op_y[1] = 4'd9; stub_lat = 6;
    pend_v = 4'b0010;
    @(posedge clk); #1;
    apply_inputs();
    @(negedge clk);
    check("rw_grant", 32'(req_ready), 32'b0010);
    @(posedge clk); #1;
    pend_v = '0;
    req_valid = '0;
    repeat (3) @(negedge clk);
    check("rw_busy_wait", 32'(busy), 32'd1);
    rstn = 1'b0;
    #1;
    check("rw_rst_outs", 32'({req_ready, rsp_valid, rsp_z, rsp_err, mul_xin, mul_yin, mul_ivalid, busy}), 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    model_ptr = NREQ - 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("rw_late_rsp", 32'(rsp_valid), 32'd0);
      check("rw_late_busy", 32'(busy), 32'd0);
    end
    op_x[0] = 4'd2; op_y[0] = 4'd8;
    op_x[3] = 4'd5; op_y[3] = 4'd5;
    stub_lat = 1;
    pend_v = 4'b1001;
    txn(1'b1);
    check("rw_sb_empty", 32'(exp_q.size()), 32'd0);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound.
  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench time limit reached");
  end

endmodule
